// File: rtl/tcb_arb.sv
// Round-robin arbiter: MN TCB managers share one TCB subordinate port.
// Optional lock support is enabled with `define TCB_ARB_LOCK_EN.
module tcb_arb #(
    parameter int unsigned MN  = 2,
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned BW  = DW/8,
    parameter int unsigned DLY = 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [MN-1:0]    man_vld,
    input  logic [MN-1:0]    man_wen,
    input  logic [MN*AW-1:0] man_adr,
    input  logic [MN*BW-1:0] man_ben,
    input  logic [MN*DW-1:0] man_wdt,
    input  logic [MN-1:0]    man_lck,
    output logic [MN-1:0]    man_rdy,
    output logic [MN-1:0]    man_rsp,
    output logic [DW-1:0]    man_rdt,
    output logic             man_err,
    output logic             sub_vld,
    output logic             sub_wen,
    output logic [AW-1:0]    sub_adr,
    output logic [BW-1:0]    sub_ben,
    output logic [DW-1:0]    sub_wdt,
    input  logic             sub_rdy,
    input  logic [DW-1:0]    sub_rdt,
    input  logic             sub_err
);

    localparam int unsigned IW = (MN > 1) ? $clog2(MN) : 1;

    typedef logic [IW-1:0] idx_t;

    logic [AW-1:0] adr_a [MN];
    logic [BW-1:0] ben_a [MN];
    logic [DW-1:0] wdt_a [MN];

    for (genvar i = 0; i < MN; i++) begin : g_unpack
        assign adr_a[i] = man_adr[i*AW +: AW];
        assign ben_a[i] = man_ben[i*BW +: BW];
        assign wdt_a[i] = man_wdt[i*DW +: DW];
    end

    idx_t ptr;
    idx_t srch;
    idx_t free_gnt;
    idx_t gnt;
    idx_t gnt_q;
    logic stall_q;
    logic trn;
    logic unused;

    function automatic idx_t nxt(input idx_t i);
        if (i == idx_t'(MN-1))
            return '0;
        else
            return i + idx_t'(1);
    endfunction

    // First requester at or after ptr, with wrap; defaults to ptr.
    always_comb begin
        logic [IW:0] s;
        logic        found;
        srch  = ptr;
        found = 1'b0;
        s     = '0;
        for (int unsigned k = 0; k < MN; k++) begin
            s = {1'b0, ptr} + (IW+1)'(k);
            if (s >= (IW+1)'(MN))
                s = s - (IW+1)'(MN);
            if (!found && man_vld[s[IW-1:0]]) begin
                srch  = s[IW-1:0];
                found = 1'b1;
            end
        end
    end

    // A stalled request keeps its grant so the subordinate sees it stable.
    assign free_gnt = (stall_q && man_vld[gnt_q]) ? gnt_q : srch;

`ifdef TCB_ARB_LOCK_EN
    logic lck_q;
    idx_t lck_own;

    always_ff @(posedge clk) begin
        if (rst) begin
            lck_q   <= 1'b0;
            lck_own <= '0;
        end else if (trn) begin
            lck_q <= man_lck[gnt];
            if (man_lck[gnt])
                lck_own <= gnt;
        end
    end

    assign gnt = lck_q ? lck_own : free_gnt;
`else
    assign gnt = free_gnt;
`endif

    assign sub_vld = man_vld[gnt];
    assign sub_wen = man_wen[gnt];
    assign sub_adr = adr_a[gnt];
    assign sub_ben = ben_a[gnt];
    assign sub_wdt = wdt_a[gnt];
    assign trn     = sub_vld & sub_rdy;

    always_comb begin
        man_rdy      = '0;
        man_rdy[gnt] = trn;
    end

    assign man_rdt = sub_rdt;
    assign man_err = sub_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            gnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            gnt_q   <= gnt;
            stall_q <= sub_vld & ~sub_rdy;
            if (trn)
                ptr <= nxt(gnt);
        end
    end

    if (DLY == 0) begin : g_nodly
        assign man_rsp = man_rdy & man_vld & {MN{~rst}};
        assign unused  = ^{man_lck, gnt_q};
    end else begin : g_dly
        logic [DLY-1:0]         pv;
        logic [DLY-1:0][IW-1:0] pi;
        logic [DLY:0]           pv_n;
        logic [DLY:0][IW-1:0]   pi_n;

        assign pv_n = {pv, trn};
        assign pi_n = {pi, gnt};

        always_ff @(posedge clk) begin
            if (rst)
                pv <= '0;
            else
                pv <= pv_n[DLY-1:0];
            pi <= pi_n[DLY-1:0];
        end

        // Gated by rst so a response in flight at reset never surfaces.
        always_comb begin
            man_rsp             = '0;
            man_rsp[pi[DLY-1]]  = pv[DLY-1] & ~rst;
        end

        assign unused = ^{man_lck, pv_n[DLY], pi_n[DLY]};
    end

endmodule
